// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave running entirely in the
//   system clock domain. SCLK, CS and MOSI are oversampled through equal-depth
//   synchronizers, and edges are detected on the synchronized copies.
//
// Ports
//   clk      : system clock, all state on rising edge
//   reset    : asynchronous active-low reset
//   SCLK     : serial clock from master (asynchronous)
//   CS       : chip select from master, active-low (asynchronous)
//   MOSI     : serial data from master
//   MISO     : serial data to master, held at 1 while idle
//   dataIN   : word to transmit, sampled at load points only
//   dataOUT  : last complete received word
//   DONE     : one-clk pulse per completed word
//   BUSY     : high while selected (state SHIFT)
//   o_state  : debug view of the FSM state (0 = IDLE, 1 = SHIFT)
//
// Handshake: a word is complete when DONE is high; dataOUT holds that word
// from the same cycle until the next completed word. There is no back-pressure.
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] dataIN,
    output logic [WIDTH-1:0] dataOUT,
    output logic             DONE,
    output logic             BUSY,
    output logic             o_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Synchronizers: all three inputs see the same delay so MOSI is stable
    // relative to the synchronized SCLK rising edge.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [WIDTH-1:0]       r_tx;
    // Only WIDTH-1 bits of received history are kept; the newest bit comes
    // straight from the synchronizer when the word is assembled.
    logic [WIDTH-2:0]       r_rx;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_data_out;
    logic                   r_done;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [WIDTH-1:0]       w_rx_next;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_rx_next   = {r_rx, w_mosi_s};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_cs_rise) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Datapath. A CS rise in the same cycle as the last SCLK rise still lets
    // the word complete, because the shift handling below does not look at CS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_tx  <= dataIN;
                        r_rx  <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_rx <= w_rx_next[WIDTH-2:0];
                        if (r_cnt == LAST_BIT) begin
                            r_cnt      <= '0;
                            r_data_out <= w_rx_next;
                            r_done     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    if (w_sclk_fall) begin
                        // Counter at 0 on a falling edge means a word boundary
                        // was just crossed: start the next word from dataIN.
                        if (r_cnt == '0) begin
                            r_tx <= dataIN;
                        end else begin
                            r_tx <= {r_tx[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // MISO is the tx MSB while selected and idles high otherwise.
    assign MISO    = (r_state == ST_SHIFT) ? r_tx[WIDTH-1] : 1'b1;
    assign dataOUT = r_data_out;
    assign DONE    = r_done;
    assign BUSY    = (r_state == ST_SHIFT);
    assign o_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        busy;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  logic [15:0] exp_q[$];
  logic        prev_done = 1'b0;

  spi_slave #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .SCLK    (sclk),
    .CS      (cs),
    .MOSI    (mosi),
    .MISO    (miso),
    .dataIN  (data_in),
    .dataOUT (data_out),
    .DONE    (done),
    .BUSY    (busy),
    .o_state (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side: clocks nbits of mosi_w out (MSB first), samples MISO just
  // before each rising edge. Optionally raises CS with the last rising edge,
  // or changes dataIN shortly after the last rising edge.
  task automatic shift_bits(input logic [15:0] mosi_w, input int nbits,
                            input bit cs_with_last, input bit chg,
                            input logic [15:0] new_din, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_w[15-i];
      tick(5);
      rx = {rx[14:0], miso};
      sclk = 1'b1;
      if (cs_with_last && i == nbits - 1) cs = 1'b1;
      if (chg && i == nbits - 1) begin
        tick(3);
        data_in = new_din;
        tick(2);
      end else begin
        tick(5);
      end
      if (!(cs_with_last && i == nbits - 1)) sclk = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        n_done++;
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_width: DONE high on consecutive cycles");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: dataOUT=%0h with no word expected", data_out);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            n_fail++;
            $display("FAIL dataOUT: got %0h expected %0h", data_out, e);
          end
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    logic [15:0] rx;
    logic [15:0] rx2;
    reset   = 1'b0;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    data_in = 16'h0000;
    tick(3);
    check("rst_miso", miso, 1);
    check("rst_dataout", data_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick(5);

    // single word
    data_in = 16'h9D5B;
    exp_q.push_back(16'hAB52);
    cs = 1'b0;
    tick(5);
    check("sel_busy", busy, 1);
    shift_bits(16'hAB52, 16, 0, 0, 16'h0, rx);
    check("single_rx", rx, 16'h9D5B);
    check("single_busy_held", busy, 1);
    tick(5);
    cs = 1'b1;
    tick(6);
    check("single_busy_off", busy, 0);
    check("single_dataout", data_out, 16'hAB52);
    check("single_miso_idle", miso, 1);

    // back-to-back with CS held low
    data_in = 16'h1234;
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'h5AA5);
    cs = 1'b0;
    tick(5);
    shift_bits(16'h0F0F, 16, 0, 1, 16'hCAFE, rx);
    shift_bits(16'h5AA5, 16, 0, 0, 16'h0, rx2);
    check("b2b_rx1", rx, 16'h1234);
    check("b2b_rx2", rx2, 16'hCAFE);
    tick(5);
    cs = 1'b1;
    tick(6);
    check("b2b_dataout", data_out, 16'h5AA5);

    // abort after 7 bits
    data_in = 16'h7777;
    cs = 1'b0;
    tick(5);
    shift_bits(16'hFFFF, 7, 0, 0, 16'h0, rx);
    tick(5);
    cs = 1'b1;
    tick(6);
    check("abort_dataout", data_out, 16'h5AA5);
    check("abort_miso", miso, 1);
    check("abort_busy", busy, 0);

    // reset after 9 bits
    data_in = 16'hA5A5;
    cs = 1'b0;
    tick(5);
    shift_bits(16'h1357, 9, 0, 0, 16'h0, rx);
    reset = 1'b0;
    #1;
    check("midrst_miso", miso, 1);
    check("midrst_dataout", data_out, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    tick(1);
    cs = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(6);
    check("midrst_idle_after", busy, 0);
    data_in = 16'h3C3C;
    exp_q.push_back(16'h00FF);
    cs = 1'b0;
    tick(5);
    shift_bits(16'h00FF, 16, 0, 0, 16'h0, rx);
    check("midrst_rx", rx, 16'h3C3C);
    tick(5);
    cs = 1'b1;
    tick(6);
    check("midrst_dataout_new", data_out, 16'h00FF);

    // idle SCLK noise
    for (int i = 0; i < 20; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
    check("noise_dataout", data_out, 16'h00FF);
    check("noise_miso", miso, 1);
    check("noise_busy", busy, 0);

    // CS rises together with the 16th SCLK rising edge
    data_in = 16'h8001;
    exp_q.push_back(16'hC3A5);
    cs = 1'b0;
    tick(5);
    shift_bits(16'hC3A5, 16, 1, 0, 16'h0, rx);
    check("bound_rx", rx, 16'h8001);
    sclk = 1'b0;
    tick(6);
    check("bound_dataout", data_out, 16'hC3A5);
    check("bound_state", state_dbg, 0);
    check("bound_miso", miso, 1);

    tick(10);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
